uop_sequencer: RTL

UOP_SEQUENCER -- requirements
Module: uop_sequencer

---
 rtl/uop_sequencer_pkg.sv | 62 ++++++
 rtl/uop_sequencer_if.sv | 31 +++
 rtl/uop_sequencer_cond_eval.sv | 21 ++
 rtl/uop_sequencer.sv | 117 +++++++++++
 4 files changed

// File: rtl/uop_sequencer_pkg.sv
// Shared microcode definitions: word layout, opcode/exec encodings and sequencer states.
// Included by the sequencer, its condition evaluator and every uop ROM.
package uop_sequencer_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned SRC_W  = 5;
    localparam int unsigned DST_W  = 4;
    localparam int unsigned EXEC_W = 2;
    localparam int unsigned WORD_W = 20;
    localparam int unsigned PC_W   = 6;
    localparam int unsigned SEL_W  = 2;

    localparam int unsigned OPC_LSB  = 16;
    localparam int unsigned SRCA_LSB = 11;
    localparam int unsigned SRCB_LSB = 6;
    localparam int unsigned DST_LSB  = 2;
    localparam int unsigned EXEC_LSB = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_RDY = 4'd0,
        OP_MOV = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_MUL = 4'd4,
        OP_INV = 4'd5
    } opcode_e;

    typedef enum logic [EXEC_W-1:0] {
        EX_ALWAYS = 2'b00,
        EX_IF_SET = 2'b01,
        EX_IF_CLR = 2'b10,
        EX_NEVER  = 2'b11
    } exec_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [SRC_W-1:0]  src_a;
        logic [SRC_W-1:0]  src_b;
        logic [DST_W-1:0]  dst;
        logic [EXEC_W-1:0] exec;
    } uword_t;

    // Split a raw ROM word into its fields using the canonical bit positions.
    function automatic uword_t unpack_uword(input logic [WORD_W-1:0] raw);
        uword_t w;
        w.opcode = raw[OPC_LSB  +: OPC_W];
        w.src_a  = raw[SRCA_LSB +: SRC_W];
        w.src_b  = raw[SRCB_LSB +: SRC_W];
        w.dst    = raw[DST_LSB  +: DST_W];
        w.exec   = raw[EXEC_LSB +: EXEC_W];
        return w;
    endfunction

endpackage

// File: rtl/uop_sequencer_if.sv
// Control, ROM and datapath signals of the microcode sequencer.
// master = surrounding system (start logic, ROM, datapath); slave = sequencer.
interface uop_sequencer_if;
    import uop_sequencer_pkg::*;

    logic              ena;
    logic [SEL_W-1:0]  prog_sel;
    logic              rdy;
    logic              err;
    logic [SEL_W-1:0]  rom_sel;
    logic [PC_W-1:0]   uop_addr;
    logic [WORD_W-1:0] uop_data;
    logic              exec_bit;
    logic              dp_ena;
    logic [OPC_W-1:0]  dp_opcode;
    logic [SRC_W-1:0]  dp_src_a;
    logic [SRC_W-1:0]  dp_src_b;
    logic [DST_W-1:0]  dp_dst;
    logic              dp_rdy;

    modport master (
        output ena, prog_sel, uop_data, exec_bit, dp_rdy,
        input  rdy, err, rom_sel, uop_addr, dp_ena, dp_opcode, dp_src_a, dp_src_b, dp_dst
    );

    modport slave (
        input  ena, prog_sel, uop_data, exec_bit, dp_rdy,
        output rdy, err, rom_sel, uop_addr, dp_ena, dp_opcode, dp_src_a, dp_src_b, dp_dst
    );

endinterface

// File: rtl/uop_sequencer_cond_eval.sv
// Turns a word's exec field and the current condition bit into an execute flag.
module uop_cond_eval
    import uop_sequencer_pkg::*;
(
    input  logic [EXEC_W-1:0] i_exec,
    input  logic              i_exec_bit,
    output logic              o_execute_c
);

    always_comb begin
        o_execute_c = 1'b0;
        case (exec_e'(i_exec))
            EX_ALWAYS: o_execute_c = 1'b1;
            EX_IF_SET: o_execute_c = i_exec_bit;
            EX_IF_CLR: o_execute_c = !i_exec_bit;
            EX_NEVER:  o_execute_c = 1'b0;
            default:   o_execute_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/uop_sequencer.sv
// Microcode sequencer: fetches words from a synchronous ROM, skips or issues
// them to the datapath, and ends on an RDY opcode or on running past address 63.
module uop_sequencer
    import uop_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    uop_sequencer_if.slave  io_uop
);

    state_e             r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_rdy;
    logic               r_err;
    logic [SEL_W-1:0]   r_rom_sel;
    logic               r_dp_ena;
    logic [OPC_W-1:0]   r_dp_opcode;
    logic [SRC_W-1:0]   r_dp_src_a;
    logic [SRC_W-1:0]   r_dp_src_b;
    logic [DST_W-1:0]   r_dp_dst;

    uword_t             w_word;
    logic               w_execute;
    logic               w_is_rdy;
    logic               w_pc_last;
    logic               w_advance;

    assign w_word    = unpack_uword(io_uop.uop_data);
    assign w_is_rdy  = (w_word.opcode == OPC_W'(OP_RDY));
    assign w_pc_last = (r_pc == {PC_W{1'b1}});

    uop_cond_eval u_cond_eval (
        .i_exec      (w_word.exec),
        .i_exec_bit  (io_uop.exec_bit),
        .o_execute_c (w_execute)
    );

    // A skipped word in DECODE and a completed word in WAIT both move to the next address.
    assign w_advance = ((r_state == ST_DECODE) && !w_is_rdy && !w_execute) ||
                       ((r_state == ST_WAIT) && io_uop.dp_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_rdy       <= 1'b1;
            r_err       <= 1'b0;
            r_rom_sel   <= '0;
            r_dp_ena    <= 1'b0;
            r_dp_opcode <= '0;
            r_dp_src_a  <= '0;
            r_dp_src_b  <= '0;
            r_dp_dst    <= '0;
        end else begin
            r_dp_ena <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_uop.ena) begin
                        r_pc      <= '0;
                        r_rom_sel <= io_uop.prog_sel;
                        r_err     <= 1'b0;
                        r_rdy     <= 1'b0;
                        r_state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    // RDY terminates regardless of its exec field; skips are handled by w_advance.
                    if (w_is_rdy) begin
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_execute) begin
                        r_dp_opcode <= w_word.opcode;
                        r_dp_src_a  <= w_word.src_a;
                        r_dp_src_b  <= w_word.src_b;
                        r_dp_dst    <= w_word.dst;
                        r_dp_ena    <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Running off the end of the ROM stops with an error instead of wrapping.
            if (w_advance) begin
                if (w_pc_last) begin
                    r_err   <= 1'b1;
                    r_rdy   <= 1'b1;
                    r_state <= ST_IDLE;
                end else begin
                    r_pc    <= r_pc + PC_W'(1);
                    r_state <= ST_FETCH;
                end
            end
        end
    end

    assign io_uop.rdy       = r_rdy;
    assign io_uop.err       = r_err;
    assign io_uop.rom_sel   = r_rom_sel;
    assign io_uop.uop_addr  = r_pc;
    assign io_uop.dp_ena    = r_dp_ena;
    assign io_uop.dp_opcode = r_dp_opcode;
    assign io_uop.dp_src_a  = r_dp_src_a;
    assign io_uop.dp_src_b  = r_dp_src_b;
    assign io_uop.dp_dst    = r_dp_dst;

endmodule
